bsg_dff_elastic_pipe: RTL and testbench
=======================================

# bsg_dff_elastic_pipe

Parametrised, multi-stage register pipeline with per-stage valid bits and a valid/ready handshake on both ends. It generalises the fixed-width hardened flop bank into a configurable-width, configurable-depth retiming pipe. Empty stages collapse bubbles, so a stall at the output backs data up stage by stage without losing throughput. It sits on long cross-tile paths in the quad, between a producer and consumer that both speak valid/ready.

## Interface
- width_p, 3: data width in bits (>=1).
- depth_p, 2: number of register stages (>=1).
- reset_val_p, 0: value loaded into every stage's data register on reset (width_p bits).
- clk_i  input  1  clock; all state updates on the rising edge.
- reset_n_i  input  1  asynchronous, active-low reset. Assertion takes effect immediately; release is synchronised externally.
- data_i  input  width_p  producer data.
- v_i  input  1  producer valid.
- ready_o  output  1  pipe can accept a word this cycle.
- data_o  output  width_p  data in the last stage.
- v_o  output  1  last stage holds a valid word.
- ready_i  input  1  consumer accepts data_o this cycle.
- count_o  output  $clog2(depth_p+1)  number of valid stages.

## Operation
- Stage k (0 = input side, depth_p-1 = output side) holds data[k] and valid bit v[k].
- Stage advance is defined from the output side back:
  - The last stage can accept when !v[last] or ready_i.
  - Stage k can accept when !v[k] or stage k+1 can accept.
- ready_o is the accept term of stage 0. It is combinational from ready_i and the valid bits, and never depends on v_i.
- Input transfer occurs when v_i and ready_o.
- Output transfer occurs when v_o and ready_i.
- On a clock edge, each stage k that can accept loads the contents of its upstream:
  - For stage 0, the upstream is data_i with valid = v_i & ready_o.
  - For any other stage, the upstream is stage k-1.
  - If the upstream valid is 0, v[k] clears and data[k] holds its old value. No load of invalid data.
- A stage that cannot accept holds both its data and its valid bit.
- data_o = data[last], v_o = v[last].
- count_o = popcount of the v[] bits. It is registered state or derived from it, with no combinational path from the inputs.
- Ordering is strictly FIFO. No word is duplicated or dropped.

## Timing
- Reset (reset_n_i = 0), applied asynchronously:
  - All v[k] clear to 0.
  - All data[k] load reset_val_p.
  - Result: v_o=0, data_o=reset_val_p, count_o=0, ready_o=1 (with the pipe empty, ready_o=1 regardless of ready_i).
- Latency through an empty pipe: a word accepted at edge n appears with v_o=1 after edge n+depth_p-1. With depth_p=1, it appears right after the accepting edge.
- Throughput: 1 word/cycle sustained when ready_i is held high.
- Full pipe (count_o=depth_p) with ready_i=0: ready_o=0, and all state holds.
- Full pipe with ready_i=1: ready_o=1. An input transfer and an output transfer occur on the same edge, and count_o is unchanged.
- Stall: while v_o=1 and ready_i=0, data_o and v_o stay stable on every edge.
- Bubble collapse: a stalled output lets upstream stages fill, up to count_o=depth_p, before ready_o drops.
- Reset asserted mid-operation discards all in-flight words immediately, regardless of the clock. The first input transfer after release follows normal empty-pipe latency.
- v_i asserted with ready_o=0 is not consumed. The producer must hold the word.

## Test plan
- Reset:
  - Stimulus: width_p=8, depth_p=3, reset_val_p=8'hA5. Assert reset_n_i low between edges.
  - Required: v_o=0, data_o=8'hA5, count_o=0, ready_o=1 before the next edge. Repeat with the pipe holding 3 words and check the same values.
- Latency:
  - Stimulus: empty pipe, ready_i=1, a single word 8'h11 with v_i for one cycle at edge n.
  - Required: v_o=1 and data_o=8'h11 after edge n+2 only, then v_o=0 after edge n+3.
- Streaming:
  - Stimulus: ready_i=1, 8'h00..8'h0F driven on consecutive cycles.
  - Required: the same 16 values out in order on 16 consecutive cycles, ready_o always 1, count_o=3 in steady state.
- Backpressure fill:
  - Stimulus: ready_i=0, drive 8'h21, 8'h22, 8'h23, 8'h24.
  - Required:
    - Three are accepted and ready_o falls after the third.
    - count_o=3, data_o=8'h21 stays stable.
    - Raise ready_i: 8'h21..8'h24 emerge in order, and the fourth is accepted on the same edge 8'h21 leaves.
- Random handshake:
  - Stimulus: random v_i/ready_i at 50%, 10k cycles, depth_p in {1,2,5}.
  - Required: a scoreboard shows no loss, duplication or reorder. count_o always equals input transfers minus output transfers.
- Mid-transfer reset:
  - Stimulus: reset with 2 words inside, then release and send 8'h7E.
  - Required: the old words never appear, and 8'h7E emerges after depth_p-1 further edges.

Source files
------------

// File: rtl/bsg_dff_elastic_pipe.sv
// Elastic register pipe: depth_p stages with per-stage valid bits and valid/ready
// on both ends. A stage loads whenever it, or anything downstream of it, has room.
module bsg_dff_elastic_pipe #(
   parameter int unsigned        width_p     = 3,
   parameter int unsigned        depth_p     = 2,
   parameter logic [width_p-1:0] reset_val_p = '0
) (
   input  logic                           clk_i,
   input  logic                           reset_n_i,
   input  logic [width_p-1:0]             data_i,
   input  logic                           v_i,
   output logic                           ready_o,
   output logic [width_p-1:0]             data_o,
   output logic                           v_o,
   input  logic                           ready_i,
   output logic [$clog2(depth_p+1)-1:0]   count_o
);
   localparam int unsigned last_lp  = depth_p - 1;
   localparam int unsigned cnt_w_lp = $clog2(depth_p + 1);

   logic [width_p-1:0] data_q [depth_p];
   logic [width_p-1:0] data_d [depth_p];
   logic [depth_p-1:0] v_q, v_d, accept;

   // Stage k accepts unless it and every stage after it are full and the consumer stalls.
   always_comb begin
      logic full_down;
      full_down = 1'b1;
      accept    = '0;
      for (int unsigned i = 0; i < depth_p; i++) begin
         full_down            = full_down & v_q[last_lp-i];
         accept[last_lp-i]    = ready_i | ~full_down;
      end
   end

   always_comb begin
      v_d = v_q;
      for (int unsigned k = 0; k < depth_p; k++)
         data_d[k] = data_q[k];
      if (accept[0]) begin
         v_d[0] = v_i;
         if (v_i)
            data_d[0] = data_i;
      end
      for (int unsigned k = 1; k < depth_p; k++) begin
         if (accept[k]) begin
            v_d[k] = v_q[k-1];
            if (v_q[k-1])
               data_d[k] = data_q[k-1];
         end
      end
   end

   always_ff @(posedge clk_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
         v_q <= '0;
         for (int unsigned k = 0; k < depth_p; k++)
            data_q[k] <= reset_val_p;
      end else begin
         v_q    <= v_d;
         data_q <= data_d;
      end
   end

   always_comb begin
      count_o = '0;
      for (int unsigned k = 0; k < depth_p; k++)
         count_o = count_o + cnt_w_lp'(v_q[k]);
   end

   assign ready_o = accept[0];
   assign data_o  = data_q[last_lp];
   assign v_o     = v_q[last_lp];

endmodule

// File: tb/tb_bsg_dff_elastic_pipe.sv
// Bench for bsg_dff_elastic_pipe: four instances (depth 3,1,2,5) share stimulus and are
// checked each cycle against a queue-of-positions model; depth 3 also gets literal checks.
module tb_bsg_dff_elastic_pipe;
   logic       clk = 1'b0;
   logic       rst_n;
   logic [7:0] data_i;
   logic       v_i;
   logic       ready_i;
   logic       done;

   logic       rdy  [4];
   logic       vo   [4];
   logic [7:0] dout [4];
   int         cnt  [4];

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   function automatic void chk(string nm, int d, int act, int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s depth=%0d actual=%0h required=%0h", nm, d, act, exp);
      end
   endfunction

   for (genvar g = 0; g < 4; g++) begin : g_inst
      localparam int D = (g == 0) ? 3 : (g == 1) ? 1 : (g == 2) ? 2 : 5;
      logic [$clog2(D+1)-1:0] cnt_l;
      logic [7:0] mq_d [$];
      int         mq_p [$];
      logic [7:0] mlast;

      bsg_dff_elastic_pipe #(.width_p(8), .depth_p(D), .reset_val_p(8'hA5)) u_dut (
         .clk_i    (clk),
         .reset_n_i(rst_n),
         .data_i   (data_i),
         .v_i      (v_i),
         .ready_o  (rdy[g]),
         .data_o   (dout[g]),
         .v_o      (vo[g]),
         .ready_i  (ready_i),
         .count_o  (cnt_l)
      );
      assign cnt[g] = int'(cnt_l);

      // Model: words in FIFO order, each with its stage position; position D means "left".
      always @(posedge clk or negedge rst_n) begin
         int limit;
         bit acc;
         if (!rst_n) begin
            mq_d.delete();
            mq_p.delete();
            mlast = 8'hA5;
         end else begin
            acc   = (mq_p.size() < D) || ready_i;
            limit = ready_i ? D + 1 : D;
            for (int i = 0; i < mq_p.size(); i++) begin
               if (mq_p[i] + 1 < limit)
                  mq_p[i] = mq_p[i] + 1;
               limit = mq_p[i];
            end
            while (mq_p.size() > 0 && mq_p[0] == D) begin
               void'(mq_p.pop_front());
               void'(mq_d.pop_front());
            end
            if (v_i && acc) begin
               mq_p.push_back(0);
               mq_d.push_back(data_i);
            end
            if (mq_p.size() > 0 && mq_p[0] == D - 1)
               mlast = mq_d[0];
         end
      end

      always @(negedge clk) begin
         if (!done) begin
            chk("v_o", D, int'(vo[g]), (mq_p.size() > 0 && mq_p[0] == D - 1) ? 1 : 0);
            chk("count_o", D, cnt[g], mq_p.size());
            chk("ready_o", D, int'(rdy[g]), (mq_p.size() < D || ready_i) ? 1 : 0);
            chk("data_o", D, int'(dout[g]), int'(mlast));
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic reset_checks(string nm);
      chk({nm, "_v"}, 3, int'(vo[0]), 0);
      chk({nm, "_data"}, 3, int'(dout[0]), 8'hA5);
      chk({nm, "_count"}, 3, cnt[0], 0);
      chk({nm, "_ready"}, 3, int'(rdy[0]), 1);
   endtask

   initial begin
      done    = 1'b0;
      rst_n   = 1'b0;
      v_i     = 1'b0;
      ready_i = 1'b0;
      data_i  = 8'h00;
      tick();
      tick();
      reset_checks("rst0");
      rst_n = 1'b1;

      // latency through an empty depth-3 pipe
      ready_i = 1'b1;
      v_i     = 1'b1;
      data_i  = 8'h11;
      tick();
      v_i = 1'b0;
      chk("lat_n0", 3, int'(vo[0]), 0);
      tick();
      chk("lat_n1", 3, int'(vo[0]), 0);
      tick();
      chk("lat_n2_v", 3, int'(vo[0]), 1);
      chk("lat_n2_d", 3, int'(dout[0]), 8'h11);
      tick();
      chk("lat_n3_v", 3, int'(vo[0]), 0);

      // streaming 0x00..0x0F
      for (int i = 0; i < 16; i++) begin
         v_i    = 1'b1;
         data_i = 8'(i);
         #1;
         chk("str_ready", 3, int'(rdy[0]), 1);
         if (i >= 3) begin
            chk("str_v", 3, int'(vo[0]), 1);
            chk("str_d", 3, int'(dout[0]), i - 3);
            chk("str_cnt", 3, cnt[0], 3);
         end
         tick();
      end
      v_i = 1'b0;
      for (int i = 13; i < 16; i++) begin
         chk("str_tail", 3, int'(dout[0]), i);
         tick();
      end
      chk("str_empty", 3, int'(vo[0]), 0);

      // backpressure fill
      ready_i = 1'b0;
      for (int i = 0; i < 3; i++) begin
         v_i    = 1'b1;
         data_i = 8'(8'h21 + i);
         #1;
         chk("bp_ready", 3, int'(rdy[0]), 1);
         tick();
      end
      data_i = 8'h24;
      #1;
      chk("bp_full_ready", 3, int'(rdy[0]), 0);
      chk("bp_full_cnt", 3, cnt[0], 3);
      chk("bp_full_d", 3, int'(dout[0]), 8'h21);
      tick();
      chk("bp_hold_d", 3, int'(dout[0]), 8'h21);
      chk("bp_hold_v", 3, int'(vo[0]), 1);
      chk("bp_hold_cnt", 3, cnt[0], 3);
      ready_i = 1'b1;
      #1;
      chk("bp_rel_ready", 3, int'(rdy[0]), 1);
      tick();
      v_i = 1'b0;
      chk("bp_out22", 3, int'(dout[0]), 8'h22);
      chk("bp_cnt3", 3, cnt[0], 3);
      tick();
      chk("bp_out23", 3, int'(dout[0]), 8'h23);
      tick();
      chk("bp_out24", 3, int'(dout[0]), 8'h24);
      chk("bp_cnt1", 3, cnt[0], 1);
      tick();
      chk("bp_empty", 3, int'(vo[0]), 0);

      // reset with a full pipe
      ready_i = 1'b0;
      for (int i = 0; i < 3; i++) begin
         v_i    = 1'b1;
         data_i = 8'(8'h41 + i);
         tick();
      end
      v_i = 1'b0;
      chk("full_cnt", 3, cnt[0], 3);
      #1 rst_n = 1'b0;
      #1 reset_checks("rst_full");
      @(posedge clk);
      #1 rst_n = 1'b1;

      // mid-transfer reset, then a fresh word
      for (int i = 0; i < 2; i++) begin
         v_i    = 1'b1;
         data_i = 8'(8'h51 + i);
         tick();
      end
      v_i = 1'b0;
      #1 rst_n = 1'b0;
      #1 reset_checks("rst_mid");
      @(posedge clk);
      #1 rst_n = 1'b1;
      ready_i = 1'b1;
      v_i     = 1'b1;
      data_i  = 8'h7E;
      tick();
      v_i = 1'b0;
      chk("mid_n0", 3, int'(vo[0]), 0);
      tick();
      chk("mid_n1", 3, int'(vo[0]), 0);
      tick();
      chk("mid_n2_v", 3, int'(vo[0]), 1);
      chk("mid_n2_d", 3, int'(dout[0]), 8'h7E);

      // random handshake
      for (int i = 0; i < 10000; i++) begin
         v_i     = 1'($urandom_range(0, 1));
         ready_i = 1'($urandom_range(0, 1));
         data_i  = 8'($urandom);
         tick();
      end
      v_i     = 1'b0;
      ready_i = 1'b1;
      for (int i = 0; i < 8; i++)
         tick();
      chk("drain_cnt", 5, cnt[3], 0);
      done = 1'b1;
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
